// File: rtl/mul_unit.sv
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit for the ARMv4 execute stage.
// Retires STEP_BITS multiplier bits per CALC cycle into a 2*DATA_W accumulator.
module mul_unit #(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic              i_long,
  input  logic              i_signed,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [DATA_W-1:0] i_acc_lo,
  input  logic [DATA_W-1:0] i_acc_hi,
  input  logic [3:0]        i_nzcv,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result_lo,
  output logic [DATA_W-1:0] o_result_hi,
  output logic [3:0]        o_nzcv
);

  localparam int N     = DATA_W / STEP_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * DATA_W;
  localparam int PP_W  = DATA_W + STEP_BITS + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              long_q, long_d;
  logic              signed_q, signed_d;
  logic [1:0]        cv_q, cv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] resLo_q, resLo_d;
  logic [DATA_W-1:0] resHi_q, resHi_d;
  logic [3:0]        nzcv_q, nzcv_d;

  logic [31:0]          shAmt;
  logic [STEP_BITS-1:0] chunk;
  logic                 lastIter;
  logic                 topNeg;
  logic [PP_W-1:0]      op1X;
  logic [PP_W-1:0]      chunkX;
  logic [PP_W-1:0]      pp;
  logic [ACC_W-1:0]     ppExt;
  logic [ACC_W-1:0]     sum;
  logic                 unusedFlags;

  // N and Z are recomputed from the result; only C and V pass through.
  assign unusedFlags = ^i_nzcv[3:2];

  // Partial product: only the top chunk of a signed multiplier has negative weight.
  always_comb begin
    shAmt    = 32'(count_q) * 32'(STEP_BITS);
    chunk    = STEP_BITS'(op2_q >> shAmt);
    lastIter = (count_q == CNT_W'(N - 1));
    topNeg   = signed_q & lastIter & chunk[STEP_BITS-1];
    op1X     = {{(PP_W-DATA_W){signed_q & op1_q[DATA_W-1]}}, op1_q};
    chunkX   = {{(PP_W-STEP_BITS){topNeg}}, chunk};
    pp       = op1X * chunkX;
    ppExt    = ACC_W'($signed(pp));
    sum      = acc_q + (ppExt << shAmt);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    long_d   = long_q;
    signed_d = signed_q;
    cv_d     = cv_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    resLo_d  = resLo_q;
    resHi_d  = resHi_q;
    nzcv_d   = nzcv_q;

    case (state_q)
      CALC: begin
        acc_d   = sum;
        count_d = count_q + CNT_W'(1);
        if (lastIter) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          resLo_d = sum[DATA_W-1:0];
          resHi_d = long_q ? sum[ACC_W-1:DATA_W] : '0;
          nzcv_d  = {long_q ? sum[ACC_W-1] : sum[DATA_W-1],
                     long_q ? (sum == '0) : (sum[DATA_W-1:0] == '0),
                     cv_q};
        end
      end
      default: begin
        state_d = IDLE;
        if (i_start) begin
          state_d  = CALC;
          busy_d   = 1'b1;
          count_d  = '0;
          op1_d    = i_op1;
          op2_d    = i_op2;
          long_d   = i_long;
          signed_d = i_signed & i_long;
          cv_d     = i_nzcv[1:0];
          acc_d    = i_acc ? {(i_long ? i_acc_hi : {DATA_W{1'b0}}), i_acc_lo} : '0;
        end
      end
    endcase

    // A flush discards the operation in flight, including a same-cycle start.
    if (i_flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      long_q   <= 1'b0;
      signed_q <= 1'b0;
      cv_q     <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resLo_q  <= '0;
      resHi_q  <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      long_q   <= long_d;
      signed_q <= signed_d;
      cv_q     <= cv_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      resLo_q  <= resLo_d;
      resHi_q  <= resHi_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_result_lo = resLo_q;
  assign o_result_hi = resHi_q;
  assign o_nzcv      = nzcv_q;

endmodule

// File: tb/tb_mul_unit.sv
// Randomised scoreboard bench for mul_unit: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever o_valid is seen.
module tb_mul_unit;

  localparam int DATA_W    = 32;
  localparam int STEP_BITS = 8;
  localparam int LATENCY   = DATA_W / STEP_BITS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_flush, i_long, i_signed, i_acc;
  logic [31:0] i_op1, i_op2, i_acc_lo, i_acc_hi;
  logic [3:0]  i_nzcv;
  logic        o_busy, o_valid;
  logic [31:0] o_result_lo, o_result_hi;
  logic [3:0]  o_nzcv;

  always #5 clk = ~clk;

  mul_unit #(.DATA_W(DATA_W), .STEP_BITS(STEP_BITS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_flush(i_flush),
    .i_long(i_long), .i_signed(i_signed), .i_acc(i_acc),
    .i_op1(i_op1), .i_op2(i_op2), .i_acc_lo(i_acc_lo), .i_acc_hi(i_acc_hi),
    .i_nzcv(i_nzcv), .o_busy(o_busy), .o_valid(o_valid),
    .o_result_lo(o_result_lo), .o_result_hi(o_result_hi), .o_nzcv(o_nzcv)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  nzcv;
    int          issue;
  } exp_t;

  exp_t        sbQ[$];
  int          totalChecks = 0;
  int          passCount = 0;
  int          cycleCount = 0;
  int          prevValidCycle = -1;
  int          lastValidCycle = -1;
  logic [31:0] lastLo = '0;
  logic [31:0] lastHi = '0;
  logic [3:0]  lastNzcv = '0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference: full-width product of the extended operands plus accumulator, mod 2^64.
  function automatic exp_t refModel(input bit isLong, input bit isSigned, input bit doAcc,
                                    input logic [31:0] op1, input logic [31:0] op2,
                                    input logic [31:0] accLo, input logic [31:0] accHi,
                                    input logic [3:0] nzcv);
    exp_t        e;
    logic [63:0] a, b, accV, full;
    a    = (isLong && isSigned) ? {{32{op1[31]}}, op1} : {32'h0, op1};
    b    = (isLong && isSigned) ? {{32{op2[31]}}, op2} : {32'h0, op2};
    accV = doAcc ? {(isLong ? accHi : 32'h0), accLo} : 64'h0;
    full = a * b + accV;
    e.lo = full[31:0];
    if (isLong) begin
      e.hi   = full[63:32];
      e.nzcv = {full[63], (full == 64'h0), nzcv[1:0]};
    end else begin
      e.hi   = 32'h0;
      e.nzcv = {full[31], (full[31:0] == 32'h0), nzcv[1:0]};
    end
    e.issue = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedValid", 64'(o_valid), 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("resultLo", 64'(o_result_lo), 64'(e.lo));
        checkOutput("resultHi", 64'(o_result_hi), 64'(e.hi));
        checkOutput("nzcv", 64'(o_nzcv), 64'(e.nzcv));
        checkOutput("latency", 64'(cycleCount - e.issue), 64'(LATENCY));
        lastLo   = e.lo;
        lastHi   = e.hi;
        lastNzcv = e.nzcv;
      end
      prevValidCycle = lastValidCycle;
      lastValidCycle = cycleCount;
    end
  end

  // Waits for the unit to be free, then presents one start for a single cycle.
  task automatic applyStimulus(input bit doExpect, input bit isLong, input bit isSigned,
                               input bit doAcc, input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] accLo, input logic [31:0] accHi,
                               input logic [3:0] nzcv, input bit withFlush);
    exp_t e;
    int   waitCycles = 0;
    @(negedge clk);
    while (o_busy && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (o_busy) checkOutput("busyTimeout", 64'(o_busy), 64'd0);
    i_long   = isLong;
    i_signed = isSigned;
    i_acc    = doAcc;
    i_op1    = op1;
    i_op2    = op2;
    i_acc_lo = accLo;
    i_acc_hi = accHi;
    i_nzcv   = nzcv;
    i_start  = 1'b1;
    i_flush  = withFlush;
    if (doExpect && !withFlush) begin
      e       = refModel(isLong, isSigned, doAcc, op1, op2, accLo, accHi, nzcv);
      e.issue = cycleCount + 1;
      sbQ.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) checkOutput("drainTimeout", 64'(sbQ.size()), 64'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_long   = 1'b0;
    i_signed = 1'b0;
    i_acc    = 1'b0;
    i_op1    = '0;
    i_op2    = '0;
    i_acc_lo = '0;
    i_acc_hi = '0;
    i_nzcv   = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(o_busy), 64'd0);
    checkOutput("resetValid", 64'(o_valid), 64'd0);
    checkOutput("resetLo", 64'(o_result_lo), 64'd0);
    checkOutput("resetHi", 64'(o_result_hi), 64'd0);
    checkOutput("resetNzcv", 64'(o_nzcv), 64'd0);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(1, 0, 0, 0, 32'h0000_1234, 32'h0000_0010, 32'h0, 32'h0, 4'b1110, 0);
    applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h2, 32'h0, 4'b0011, 0);
    applyStimulus(1, 1, 1, 0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0, 4'b0000, 0);
    applyStimulus(1, 1, 0, 0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0, 4'b0101, 0);
    applyStimulus(1, 1, 0, 1, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 0);
    waitDrain();
    checkOutput("backToBackGap", 64'(lastValidCycle - prevValidCycle), 64'(LATENCY + 1));

    $display("[TB] flush in second CALC cycle");
    applyStimulus(0, 1, 1, 1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h1111_1111, 32'h2222_2222, 4'b0110, 0);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checkOutput("flushBusy", 64'(o_busy), 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("flushKeepLo", 64'(o_result_lo), 64'(lastLo));
    checkOutput("flushKeepHi", 64'(o_result_hi), 64'(lastHi));
    checkOutput("flushKeepNzcv", 64'(o_nzcv), 64'(lastNzcv));

    $display("[TB] start and flush together");
    applyStimulus(0, 0, 0, 0, 32'h0000_0005, 32'h0000_0007, 32'h0, 32'h0, 4'b0011, 1);
    checkOutput("startFlushBusy", 64'(o_busy), 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("startFlushKeepLo", 64'(o_result_lo), 64'(lastLo));

    $display("[TB] randomised operations");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                    pickOperand(), pickOperand(), 4'($urandom), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    waitDrain();

    $display("[TB] reset in third CALC cycle");
    applyStimulus(0, 1, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0011, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", 64'(o_busy), 64'd0);
    checkOutput("midResetValid", 64'(o_valid), 64'd0);
    checkOutput("midResetLo", 64'(o_result_lo), 64'd0);
    checkOutput("midResetHi", 64'(o_result_hi), 64'd0);
    checkOutput("midResetNzcv", 64'(o_nzcv), 64'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    lastLo   = '0;
    lastHi   = '0;
    lastNzcv = '0;
    repeat (8) @(negedge clk);
    checkOutput("postResetLo", 64'(o_result_lo), 64'd0);

    applyStimulus(1, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 0);
    applyStimulus(1, 0, 0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 4'b0010, 0);
    waitDrain();

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
